// File: rtl/patch_embed_reader.sv
// Patch-embedding RAM stream reader with 2-cycle read latency absorbed by a credit FIFO.
// Optional frame popcount accumulator enabled by PE_READ_POPCNT_EN.
module patch_embed_reader #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                s_clk,
    input  logic                s_rst_n,
    input  logic                i_start,
    input  logic [ADDR_W:0]     i_num_words,
    input  logic                i_ramout_ready,
    output logic [ADDR_W-1:0]   o_rd_addr,
    input  logic [DATA_W-1:0]   i_rdata,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [DATA_W-1:0]   o_data,
    output logic [DATA_W/2-1:0] o_spk_any,
    output logic [DATA_W/2-1:0] o_spk_both,
    output logic                o_last,
    output logic                o_busy,
    output logic                o_done,
    output logic [17:0]         o_popcnt
);

    localparam int EW = DATA_W / 2;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int NW = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RDY,
        READ,
        DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [NW-1:0]         num_q, num_d;
    logic [NW-1:0]         iss_q, iss_d;
    logic [NW-1:0]         rcv_q, rcv_d;
    logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
    logic [2:0]            pipe_q, pipe_d;
    logic [DATA_W-1:0]     mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]     mem_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] lst_q, lst_d;
    logic [PW-1:0]         wp_q, wp_d;
    logic [PW-1:0]         rp_q, rp_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  push;
    logic                  pop;
    logic                  issue;
    int                    occ;

    assign o_valid   = (cnt_q != '0);
    assign pop       = o_valid && i_ready;
    assign push      = pipe_q[2];
    assign o_data    = mem_q[rp_q];
    assign o_last    = o_valid && lst_q[rp_q];
    assign o_rd_addr = rd_addr_q;
    assign o_busy    = (state_q != IDLE);
    assign o_done    = done_q;

    always_comb begin
        for (int k = 0; k < EW; k++) begin
            o_spk_any[k]  = o_data[2*k] | o_data[2*k+1];
            o_spk_both[k] = o_data[2*k+1];
        end
    end

    // Committed slots = FIFO entries plus reads still in the RAM pipe;
    // a same-cycle pop frees one slot so a full-rate stream never stalls.
    always_comb begin
        occ = int'(cnt_q) + int'(pipe_q[0]) + int'(pipe_q[1])
            + int'(pipe_q[2]);
        issue = (state_q == READ)
             && (occ + 1 <= FIFO_DEPTH + int'(pop));
    end

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        iss_d     = iss_q;
        rcv_d     = rcv_q;
        rd_addr_d = rd_addr_q;
        pipe_d    = {pipe_q[1:0], issue};
        mem_d     = mem_q;
        lst_d     = lst_q;
        wp_d      = wp_q;
        rp_d      = rp_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    num_d = i_num_words;
                    iss_d = '0;
                    rcv_d = '0;
                    if (i_num_words == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = WAIT_RDY;
                    end
                end
            end
            WAIT_RDY: begin
                if (i_ramout_ready) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (issue) begin
                    rd_addr_d = iss_q[ADDR_W-1:0];
                    iss_d     = iss_q + NW'(1);
                    if (iss_q == num_q - NW'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && o_last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (push) begin
            mem_d[wp_q] = i_rdata;
            lst_d[wp_q] = (rcv_q == num_q - NW'(1));
            rcv_d       = rcv_q + NW'(1);
            wp_d = (wp_q == PW'(FIFO_DEPTH - 1)) ? '0 : wp_q + PW'(1);
        end
        if (pop) begin
            rp_d = (rp_q == PW'(FIFO_DEPTH - 1)) ? '0 : rp_q + PW'(1);
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q   <= IDLE;
            num_q     <= '0;
            iss_q     <= '0;
            rcv_q     <= '0;
            rd_addr_q <= '0;
            pipe_q    <= '0;
            mem_q     <= '{default: '0};
            lst_q     <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            iss_q     <= iss_d;
            rcv_q     <= rcv_d;
            rd_addr_q <= rd_addr_d;
            pipe_q    <= pipe_d;
            mem_q     <= mem_d;
            lst_q     <= lst_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
        end
    end

`ifdef PE_READ_POPCNT_EN
    localparam int WSW = $clog2(3 * EW + 1);

    logic [17:0]    popcnt_q, popcnt_d;
    logic [WSW-1:0] wsum;
    logic [18:0]    acc;

    // Element value is sum + 2*carry, so odd bits weigh double.
    always_comb begin
        wsum = '0;
        for (int k = 0; k < EW; k++) begin
            wsum = wsum + WSW'(o_data[2*k])
                 + WSW'({o_data[2*k+1], 1'b0});
        end
        acc      = {1'b0, popcnt_q} + 19'(wsum);
        popcnt_d = popcnt_q;
        if (state_q == IDLE && i_start) begin
            popcnt_d = '0;
        end else if (pop) begin
            popcnt_d = acc[18] ? '1 : acc[17:0];
        end
    end

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            popcnt_q <= '0;
        end else begin
            popcnt_q <= popcnt_d;
        end
    end

    assign o_popcnt = popcnt_q;
`else
    assign o_popcnt = '0;
`endif

endmodule
